// File: rtl/ysyx_220053_pipe_stage.sv
// Ready/valid pipeline stage with a DEPTH-entry in-order buffer for the ysyx_220053 core.
// Define YSYX_220053_PIPE_PERF_EN to add saturating stall/bubble performance counters.
module ysyx_220053_pipe_stage #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       occupancy
`ifdef YSYX_220053_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]      FULL  = 3'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]       occ_q, occ_d;
  logic             push, pop;

  // Wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake flags depend on registered occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = (occ_q != FULL);
  assign out_valid = (occ_q != 3'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_d = occ_q + 3'd1;
        2'b01:   occ_d = occ_q - 3'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset too so out_data reads a defined zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

`ifdef YSYX_220053_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Counters saturate at all-ones and ignore flush.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (!out_valid && (bubble_cnt_q != '1))             bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_220053_pipe_stage.sv
// Bench for ysyx_220053_pipe_stage: DEPTH=2 and DEPTH=3 instances share one stimulus
// stream, each checked every cycle against its own queue model.
module tb_ysyx_220053_pipe_stage;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         in_ready2, out_valid2, in_ready3, out_valid3;
  logic [W-1:0] out_data2, out_data3;
  logic [2:0]   occ2, occ3;
`ifdef YSYX_220053_PIPE_PERF_EN
  logic [3:0]   st2, bb2, st3, bb3;
  int           m_st2, m_bb2, m_st3, m_bb3;
`endif

  ysyx_220053_pipe_stage #(.WIDTH(W), .DEPTH(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .occupancy(occ2)
`ifdef YSYX_220053_PIPE_PERF_EN
    , .stall_cnt(st2), .bubble_cnt(bb2)
`endif
  );

  ysyx_220053_pipe_stage #(.WIDTH(W), .DEPTH(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .occupancy(occ3)
`ifdef YSYX_220053_PIPE_PERF_EN
    , .stall_cnt(st3), .bubble_cnt(bb3)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [W-1:0] q2[$];
  logic [W-1:0] q3[$];
  logic acc2;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs, then advance the models.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    logic push2, pop2, push3, pop3;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    check("occ_d2",       W'(occ2),       W'(q2.size()));
    check("in_ready_d2",  W'(in_ready2),  W'(q2.size() != 2));
    check("out_valid_d2", W'(out_valid2), W'(q2.size() != 0));
    if (q2.size() != 0) check("out_data_d2", out_data2, q2[0]);
    check("occ_d3",       W'(occ3),       W'(q3.size()));
    check("in_ready_d3",  W'(in_ready3),  W'(q3.size() != 3));
    check("out_valid_d3", W'(out_valid3), W'(q3.size() != 0));
    if (q3.size() != 0) check("out_data_d3", out_data3, q3[0]);
`ifdef YSYX_220053_PIPE_PERF_EN
    check("stall_d2",  W'(st2), W'(m_st2));
    check("bubble_d2", W'(bb2), W'(m_bb2));
    check("stall_d3",  W'(st3), W'(m_st3));
    check("bubble_d3", W'(bb3), W'(m_bb3));
    if (q2.size() != 0 && !ordy && m_st2 < 15) m_st2++;
    if (q2.size() == 0 && m_bb2 < 15) m_bb2++;
    if (q3.size() != 0 && !ordy && m_st3 < 15) m_st3++;
    if (q3.size() == 0 && m_bb3 < 15) m_bb3++;
`endif
    push2 = iv && (q2.size() != 2) && !fl;
    pop2  = (q2.size() != 0) && ordy && !fl;
    push3 = iv && (q3.size() != 3) && !fl;
    pop3  = (q3.size() != 0) && ordy && !fl;
    acc2  = push2;
    if (fl) begin
      q2.delete();
      q3.delete();
    end else begin
      if (pop2)  void'(q2.pop_front());
      if (push2) q2.push_back(id);
      if (pop3)  void'(q3.pop_front());
      if (push3) q3.push_back(id);
    end
  endtask

  // Asynchronous reset pulse in the middle of a low clock phase.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    #1;
    check("rst_occ2",       W'(occ2),       '0);
    check("rst_in_ready2",  W'(in_ready2),  W'(1));
    check("rst_out_valid2", W'(out_valid2), '0);
    check("rst_out_data2",  out_data2,      '0);
    check("rst_occ3",       W'(occ3),       '0);
    check("rst_out_data3",  out_data3,      '0);
`ifdef YSYX_220053_PIPE_PERF_EN
    check("rst_stall2",  W'(st2), '0);
    check("rst_bubble2", W'(bb2), '0);
    // The idle edge right after release is one bubble cycle.
    m_st2 = 0; m_bb2 = 1; m_st3 = 0; m_bb3 = 1;
`endif
    q2.delete();
    q3.delete();
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; acc2 = 1'b0;
    do_reset();

    // Streaming with out_ready held high.
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: third item waits until the DEPTH=2 stage has room.
    step(1'b1, 16'h000A, 1'b0, 1'b0);
    step(1'b1, 16'h000B, 1'b0, 1'b0);
    step(1'b1, 16'h000C, 1'b0, 1'b0);
    check("c_held_back", W'(acc2), '0);
    for (int k = 0; k < 10 && !acc2; k++) step(1'b1, 16'h000C, 1'b1, 1'b0);
    check("c_accepted", W'(acc2), W'(1));
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);

    // Random downstream readiness; exercises pointer wrap on both depths.
    for (int i = 0; i < 30; i++)
      step(1'($urandom_range(0, 3) != 0), W'(16'h0100 + i), 1'($urandom_range(0, 1)), 1'b0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full, colliding with a push and a pop.
    step(1'b1, 16'h0021, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0);
    step(1'b1, 16'h0023, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 16'h0025, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

    // Reset while entries are buffered, then a fresh transfer.
    step(1'b1, 16'h0031, 1'b0, 1'b0);
    step(1'b1, 16'h0032, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 16'h0039, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);

`ifdef YSYX_220053_PIPE_PERF_EN
    // Stall counter saturation, unaffected by flush.
    do_reset();
    step(1'b1, 16'h0041, 1'b0, 1'b0);
    repeat (20) step(1'b0, '0, 1'b0, 1'b0);
    check("stall_sat", W'(st2), W'(15));
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("stall_after_flush", W'(st2), W'(15));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
